// File: rtl/cla2_serial_adder_if.sv
// cla2_serial_adder_if
//   Request/result bundle between a sequencer (master) and the serial
//   CLA adder controller (slave).
//   Handshake: the master raises start with a, b and cin valid; the
//   controller accepts them on the first rising edge that finds it idle
//   (busy=0). While busy=1, start is ignored and not queued. done pulses
//   for exactly one cycle when sum/cout/overflow are final; those results
//   then hold until the next accepted start or reset.
//   Signals:
//     start    - request (master -> slave)
//     a, b     - WIDTH-bit operands (master -> slave)
//     cin      - carry-in (master -> slave)
//     busy     - operation in progress or completing (slave -> master)
//     done     - one-cycle completion pulse (slave -> master)
//     sum      - registered WIDTH-bit result (slave -> master)
//     cout     - carry out of the MSB (slave -> master)
//     overflow - two's-complement overflow (slave -> master)
interface cla2_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/cla2_serial_adder.sv
// cla2_serial_adder
//   Multi-cycle WIDTH-bit adder. Operands are latched on the accepting edge
//   and fed through a single 2-bit carry-lookahead slice, one digit pair per
//   clock, least-significant first. The slice carry is rechained through
//   c_reg_q. Start-to-done latency is WIDTH/2 edges.
//   Ports:
//     clk     - rising-edge clock
//     rst     - synchronous active-high reset
//     bus     - cla2_serial_adder_if slave modport (request and result)
//     state_o - current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation

// cla2: 2-bit carry-lookahead slice.
//   a_i, b_i - 2-bit digit pair; c_i - carry in
//   s_o      - 2-bit sum; c1_o - carry into bit 1; c2_o - carry out
module cla2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       c_i,
  output logic [1:0] s_o,
  output logic       c1_o,
  output logic       c2_o
);
  logic [1:0] g;
  logic [1:0] p;

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c1_o = g[0] | (p[0] & c_i);
  assign c2_o = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign s_o  = p ^ {c1_o, c_i};
endmodule

module cla2_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  cla2_serial_adder_if.slave       bus,
  output logic [1:0]               state_o
);
  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             c_reg_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0] slice_s;
  logic       slice_c1;
  logic       slice_c2;

  // The low digit of each shift register is always the one being added.
  cla2 u_slice (
    .a_i  (a_sh_q[1:0]),
    .b_i  (b_sh_q[1:0]),
    .c_i  (c_reg_q),
    .s_o  (slice_s),
    .c1_o (slice_c1),
    .c2_o (slice_c2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      c_reg_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= RUN;
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            c_reg_q <= bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          sum_q[2*int'(idx_q) +: 2] <= slice_s;
          c_reg_q <= slice_c2;
          a_sh_q  <= a_sh_q >> 2;
          b_sh_q  <= b_sh_q >> 2;
          if (idx_q == LAST) begin
            // Last digit: its carries are the carry into and out of the MSB.
            state_q <= DONE;
            done_q  <= 1'b1;
            cout_q  <= slice_c2;
            ovf_q   <= slice_c1 ^ slice_c2;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_cla2_serial_adder.sv
// tb_cla2_serial_adder
//   Directed bench for cla2_serial_adder (WIDTH=8). Expected results come
//   from a behavioural adder model and are queued when a start is driven
//   that will be accepted; they are popped when done is seen.
module tb_cla2_serial_adder;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] state;

  cla2_serial_adder_if #(.WIDTH(W)) bus ();

  cla2_serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Packed as {overflow, cout, sum}.
  logic [W+1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a request that the DUT will accept on the next edge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    exp_q.push_back(model(a, b, cin));
  endtask

  // Called just after the accepting edge; counts edges until done.
  task automatic wait_done(input string tag, input bit scramble);
    int lat;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 12) begin
      if (scramble) begin
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.cin = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 4);
  endtask

  task automatic check_result(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, bus.sum, e[W-1:0]);
      chk({tag, "_cout"}, bus.cout, e[W]);
      chk({tag, "_ovf"}, bus.overflow, e[W+1]);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit scramble);
    drive_start(a, b, cin);
    step();
    bus.start = 1'b0;
    wait_done(tag, scramble);
    check_result(tag);
    step();
    chk({tag, "_done_low"}, bus.done, 0);
    chk({tag, "_busy_low"}, bus.busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit saw_done;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom_range(0, 1));
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst       = 1'b0;
    bus.start = 1'b0;
    step();

    // Carry-in only and full-ripple cases.
    run_op("cin_only", 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("ripple_ff", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("ovf_7f", 8'h7F, 8'h01, 1'b0, 1'b0);

    // Start held high through RUN and DONE must not be queued.
    drive_start(8'h12, 8'h34, 1'b0);
    step();
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    wait_done("hold1", 1'b0);
    check_result("hold1");
    step();
    chk("hold_gap_busy", bus.busy, 0);
    chk("hold_gap_done", bus.done, 0);
    exp_q.push_back(model(8'hFF, 8'hFF, 1'b0));
    step();
    bus.start = 1'b0;
    chk("hold2_busy", bus.busy, 1);
    wait_done("hold2", 1'b0);
    check_result("hold2");
    step();

    // Reset in the middle of an operation.
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.cin   = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_sum", bus.sum, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      step();
    end
    chk("abort_no_done", saw_done, 0);
    run_op("after_abort", 8'hA5, 8'h5A, 1'b1, 1'b0);

    // Inputs wiggling after acceptance must not disturb the result.
    run_op("stable", 8'h80, 8'h80, 1'b0, 1'b1);

    // A few random operands for breadth.
    for (int i = 0; i < 6; i++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cla2_serial_adder.md
# cla2_serial_adder

Multi-cycle WIDTH-bit adder controller built around the existing 2-bit carry-lookahead slice (`cla2`). The controller latches two operands and a carry-in, then feeds one 2-bit digit pair per clock through a single `cla2` instance, least-significant pair first. It rechains the slice carry through a carry register and assembles the registered sum. It also reports carry-out and signed overflow, and signals completion with a one-cycle `done` pulse. It sits between a requesting sequencer and the shared `cla2` datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/sum width in bits; must be even and >= 2; digit count N = WIDTH/2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; captured on the accepting edge
- b  in  WIDTH  operand B; captured on the accepting edge
- cin  in  1  carry-in; captured on the accepting edge
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse (high in DONE)
- sum  out  WIDTH  registered result, held until next accepted start or reset
- cout  out  1  carry out of bit WIDTH-1, held like sum
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB, held like sum

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when start=1:
  - a_sh<=a, b_sh<=b, c_reg<=cin, idx<=0
  - sum<=0, cout<=0, overflow<=0
- RUN, every edge:
  - slice inputs are a_sh[1:0], b_sh[1:0] and c_reg
  - sum[2*idx+1:2*idx] <= slice s
  - c_reg <= slice carry2
  - a_sh and b_sh shift right by 2; idx <= idx+1
- RUN -> DONE on the edge where idx == N-1:
  - cout <= carry2 of that last slice
  - overflow <= carry1 XOR carry2 of that last slice (carry1 is the carry into bit WIDTH-1)
- DONE -> IDLE unconditionally on the next edge.
- Operands and cin changing after the accepting edge have no effect.
- start in RUN or DONE is ignored and not queued.
- Arithmetic is unsigned modulo 2^WIDTH. The WIDTH+1-bit result is {cout, sum}. overflow is meaningful for two's-complement operands.
- idx is ceil(log2(N)) bits wide; it never wraps because RUN exits at N-1.
- rst=1 overrides everything on the same edge:
  - state <= IDLE
  - sum, cout, overflow, c_reg, idx and shift registers <= 0
  - busy and done go low
  - an operation in progress is aborted with no partial result kept
- rst and start both high on the same edge: reset wins, and start is not accepted.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0.
- Edge E0 samples start=1 in IDLE.
- Edges E1..EN each compute one digit.
- After EN: done=1 and sum/cout/overflow are final. Start-to-done latency is N edges (4 for WIDTH=8).
- busy is high from after E0 through the DONE cycle and is low again after EN+1.
- A new start is accepted no earlier than edge EN+2 (first IDLE cycle). Minimum issue interval is N+2 edges.
- Partial sum bits are visible during RUN. Consumers use sum only when done=1 or later.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst for 2 edges with random inputs and start=1 -> busy=0, done=0, sum=8'h00, cout=0, overflow=0.
- Carry-in only: a=8'h00, b=8'h00, cin=1, start pulsed -> done exactly 4 edges after the accepting edge, sum=8'h01, cout=0, overflow=0; done low on the following cycle.
- Full ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1.
- Start during operation:
  - accept a=8'h12, b=8'h34, cin=0
  - hold start=1 with a=8'hFF, b=8'hFF throughout RUN and DONE
  - required: sum=8'h46, cout=0 at done
  - then a second operation starts at the first IDLE edge and yields sum=8'hFE, cout=1, overflow=0
- Reset mid-operation: accept a=8'hFF, b=8'hFF; assert rst on E2 -> next cycle busy=0, sum=0, no done pulse. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, overflow=0.
- Operand stability: change a, b and cin every cycle after an accepted a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, overflow=1.
